pulse_sequencer: RTL and testbench
==================================

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, width of the period, count and index fields.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  burst request; sampled only in IDLE.
REQ-005 Port: abort  input  1  terminates the current burst.
REQ-006 Port: period  input  WIDTH  cycles between pulses; 0 is treated as 1.
REQ-007 Port: count  input  WIDTH  pulses per burst; 0 means an empty burst.
REQ-008 Port: OUT  output  1  registered one-cycle pulse train.
REQ-009 Port: busy  output  1  registered; high whenever state is not IDLE.
REQ-010 Port: done  output  1  registered one-cycle burst-completion strobe.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE; busy = (state != IDLE).
REQ-012 In IDLE with start=1 and abort=0 at edge E0, the block SHALL capture P = max(period,1) and count into internal shadow registers.
REQ-013 At that edge, the FSM SHALL go to RUN if count != 0, else to DONE.
REQ-014 period and count changes after capture SHALL have no effect until the next accepted start.
REQ-015 In RUN, OUT SHALL go high for exactly one cycle at edges E0+k*P, for k = 1..count.
REQ-016 OUT SHALL be low at all other times; with P=1, OUT stays high for count consecutive cycles.
REQ-017 The timer and remaining-pulse counter SHALL be WIDTH bits wide, with no wrap-around inside a burst.
REQ-018 The timer SHALL reset to 0 on each pulse.
REQ-019 At edge E0+count*P, the block SHALL raise done together with the final OUT pulse and enter DONE.
REQ-020 The DONE state SHALL last one cycle, then the FSM SHALL return to IDLE; done SHALL be high only in the DONE cycle.
REQ-021 For count=0, the FSM SHALL enter DONE at E0: done high for one cycle after E0, with no OUT pulse.
REQ-022 start SHALL be ignored in RUN and DONE; no request is queued.
REQ-023 abort=1 in RUN SHALL force IDLE at the next edge with OUT=0 and done=0, even if a pulse was due that edge.
REQ-024 abort SHALL have no effect in DONE.
REQ-025 When start and abort are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for clk, force the following:
  - state = IDLE
  - OUT = 0, busy = 0, done = 0
  - timer, remaining-pulse counter and shadow registers = 0
REQ-027 Reset SHALL apply in any state, including mid-burst; no done SHALL be produced for the interrupted burst.
REQ-028 After reset deasserts, the first edge SHALL behave as IDLE.

Configuration
REQ-029 When macro PULSE_SEQUENCER_IDX_EN is defined, the block SHALL add an output pulse_idx (WIDTH bits) with this behaviour:
  - equals the number of pulses emitted in the current burst
  - incremented on the same edge as each OUT pulse
  - cleared on accepted start and on reset
  - holds its value in DONE and IDLE until the next accepted start
REQ-030 When PULSE_SEQUENCER_IDX_EN is undefined, the pulse_idx port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-031 period=5, count=3, start at edge 0 -> OUT high after edges 5, 10, 15; done with edge 15; busy low after edge 16; pulse_idx 1, 2, 3 (macro on).
REQ-032 period=0, count=2 -> OUT high after edges 1 and 2 (back-to-back); done with edge 2.
REQ-033 count=0, start at edge 0 -> done high for one cycle after edge 0, OUT never high; busy low after edge 1.
REQ-034 period=4, count=5, abort asserted at edge 6 -> exactly one OUT pulse (edge 4); no done; busy low after edge 6.
REQ-035 Mid-RUN, reset asserted between edges -> OUT, busy, done low immediately; after release, start gives a fresh burst with newly captured period/count.
REQ-036 During RUN, start pulsed and period changed 5 -> 2 -> ignored; pulse spacing stays 5 and no second burst follows done.

Source files
------------

// File: rtl/pulse_sequencer_if.sv
// Bus between a burst requester and pulse_sequencer.
// PULSE_SEQUENCER_IDX_EN adds the pulse_idx field.
interface pulse_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count;
    logic             OUT;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;
`ifdef PULSE_SEQUENCER_IDX_EN
    logic [WIDTH-1:0] pulse_idx;

    modport master (
        output start, abort, period, count,
        input  OUT, busy, done, state_dbg, pulse_idx
    );

    modport slave (
        input  start, abort, period, count,
        output OUT, busy, done, state_dbg, pulse_idx
    );
`else
    modport master (
        output start, abort, period, count,
        input  OUT, busy, done, state_dbg
    );

    modport slave (
        input  start, abort, period, count,
        output OUT, busy, done, state_dbg
    );
`endif
endinterface

// File: rtl/pulse_sequencer.sv
// Burst pulse generator: on an accepted start, emits count one-cycle pulses spaced period cycles apart.
// Optional feature macro: PULSE_SEQUENCER_IDX_EN (adds pulse_idx, the running pulse number).
module pulse_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    pulse_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] remain_q;
    logic [WIDTH-1:0] timer_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             fire;
    logic             last_pulse;
    logic [WIDTH-1:0] period_eff;

    // Handshake: start is a request taken only while busy is low (IDLE) and
    // abort is low; busy high means no new request is accepted or queued.
    always_comb begin
        accept     = 1'b0;
        fire       = 1'b0;
        last_pulse = 1'b0;
        period_eff = bus.period;
        if (bus.period == '0) begin
            period_eff = WIDTH'(1);
        end
        if (state_q == S_IDLE && bus.start && !bus.abort) begin
            accept = 1'b1;
        end
        // Timer counts 0..P-1 so it never needs a value of P.
        if (state_q == S_RUN && !bus.abort && timer_q == period_q - WIDTH'(1)) begin
            fire = 1'b1;
        end
        if (fire && remain_q == WIDTH'(1)) begin
            last_pulse = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            period_q <= '0;
            remain_q <= '0;
            timer_q  <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        period_q <= period_eff;
                        remain_q <= bus.count;
                        timer_q  <= '0;
                        busy_q   <= 1'b1;
                        if (bus.count != '0) begin
                            state_q <= S_RUN;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                    end else if (fire) begin
                        pulse_q  <= 1'b1;
                        timer_q  <= '0;
                        remain_q <= remain_q - WIDTH'(1);
                        if (last_pulse) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PULSE_SEQUENCER_IDX_EN
    logic [WIDTH-1:0] idx_q;

    // Holds after DONE or abort so the last burst's pulse count stays readable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= '0;
        end else if (fire) begin
            idx_q <= idx_q + WIDTH'(1);
        end
    end

    assign bus.pulse_idx = idx_q;
`endif

    assign bus.OUT       = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer; edge 0 is the edge that samples start.
module tb_pulse_sequencer;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  pulse_sequencer_if #(.WIDTH(WIDTH)) bus ();

  pulse_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idx(input string tag, input int exp);
`ifdef PULSE_SEQUENCER_IDX_EN
    check(tag, 32'(bus.pulse_idx), 32'(exp));
`endif
  endtask

  // Drive start for edge 0, then check every edge 1..last_edge.
  task automatic run_burst(input string tag, input int p, input int c, input int last_edge);
    int ep;
    int fin;
    ep  = (p == 0) ? 1 : p;
    fin = c * ep;
    bus.period = WIDTH'(p);
    bus.count  = WIDTH'(c);
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    check({tag, "_e0_busy"}, 32'(bus.busy), 1);
    check({tag, "_e0_out"},  32'(bus.OUT), 0);
    check({tag, "_e0_done"}, 32'(bus.done), (c == 0) ? 1 : 0);
    check_idx({tag, "_e0_idx"}, 0);
    for (int e = 1; e <= last_edge; e++) begin
      int exp_out;
      int exp_idx;
      tick();
      exp_out = (c != 0 && (e % ep) == 0 && (e / ep) <= c) ? 1 : 0;
      exp_idx = (c == 0) ? 0 : (((e / ep) < c) ? (e / ep) : c);
      check($sformatf("%s_e%0d_out", tag, e),  32'(bus.OUT), 32'(exp_out));
      check($sformatf("%s_e%0d_done", tag, e), 32'(bus.done), (c != 0 && e == fin) ? 1 : 0);
      check($sformatf("%s_e%0d_busy", tag, e), 32'(bus.busy), (c != 0 && e <= fin) ? 1 : 0);
      check_idx($sformatf("%s_e%0d_idx", tag, e), exp_idx);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.period = '0;
    bus.count  = '0;
    tick();
    tick();
    check("rst_out",   32'(bus.OUT), 0);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_state", 32'(bus.state_dbg), 0);
    check_idx("rst_idx", 0);
    reset = 1'b0;
    tick();
    check("post_rst_busy", 32'(bus.busy), 0);

    // period 5, count 3: pulses at 5, 10, 15; busy low after 16
    run_burst("p5c3", 5, 3, 18);
    // period 0 behaves as 1: back-to-back pulses
    run_burst("p0c2", 0, 2, 4);
    // empty burst: done right after edge 0, no pulse
    run_burst("c0", 7, 0, 3);
    // period 1, count 4
    run_burst("p1c4", 1, 4, 6);

    // start and abort together in IDLE: abort wins
    bus.period = 8'd2;
    bus.count  = 8'd2;
    bus.start  = 1'b1;
    bus.abort  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    check("sa_busy",  32'(bus.busy), 0);
    check("sa_state", 32'(bus.state_dbg), 0);
    tick();
    tick();
    check("sa_out", 32'(bus.OUT), 0);
    check_idx("sa_idx", 4);

    // abort sampled at edge 6 of period 4, count 5
    bus.period = 8'd4;
    bus.count  = 8'd5;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      bus.abort = (e == 6);
      tick();
      check($sformatf("ab_e%0d_out", e),  32'(bus.OUT), (e == 4) ? 1 : 0);
      check($sformatf("ab_e%0d_done", e), 32'(bus.done), 0);
      check($sformatf("ab_e%0d_busy", e), 32'(bus.busy), (e < 6) ? 1 : 0);
    end
    bus.abort = 1'b0;
    check_idx("ab_idx_hold", 1);

    // abort on the edge a pulse is due suppresses it
    bus.period = 8'd3;
    bus.count  = 8'd2;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    tick();
    tick();
    bus.abort  = 1'b1;
    tick();
    bus.abort  = 1'b0;
    check("abdue_out",  32'(bus.OUT), 0);
    check("abdue_busy", 32'(bus.busy), 0);
    check("abdue_done", 32'(bus.done), 0);
    check_idx("abdue_idx", 0);

    // start pulse and period/count change during RUN are ignored
    bus.period = 8'd5;
    bus.count  = 8'd2;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      bus.start = (e == 2);
      if (e == 2) begin
        bus.period = 8'd2;
        bus.count  = 8'd7;
      end
      tick();
      check($sformatf("ign_e%0d_out", e),  32'(bus.OUT), (e == 5 || e == 10) ? 1 : 0);
      check($sformatf("ign_e%0d_done", e), 32'(bus.done), (e == 10) ? 1 : 0);
      check($sformatf("ign_e%0d_busy", e), 32'(bus.busy), (e <= 10) ? 1 : 0);
    end
    bus.start = 1'b0;

    // asynchronous reset mid-burst while OUT is high
    bus.period = 8'd3;
    bus.count  = 8'd4;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    tick();
    tick();
    tick();
    check("mr_out_pre", 32'(bus.OUT), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_out",   32'(bus.OUT), 0);
    check("mr_busy",  32'(bus.busy), 0);
    check("mr_done",  32'(bus.done), 0);
    check("mr_state", 32'(bus.state_dbg), 0);
    check_idx("mr_idx", 0);
    tick();
    reset = 1'b0;
    tick();
    check("mr_idle_done", 32'(bus.done), 0);
    check("mr_idle_busy", 32'(bus.busy), 0);
    run_burst("fresh", 2, 1, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
